instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Front end of the MIPS core: owns the PC, fetches instructions from instruction memory over a
//  req/ack handshake, and presents one instruction at a time to decode and the controller.
//  On retire it consumes the controller's redirect outputs (pcsrc, jump, jumpr) and forms the next PC.
//  Sits between imem and controller/datapath; replaces the single-cycle PC register + next-PC muxes.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  ACK_TIMEOUT  16             max cycles imem_req may wait for imem_ack before fetch_err
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  imem_req     out  1   fetch request, held until imem_ack
//  imem_addr    out  32  word-aligned fetch address (= pc while imem_req)
//  imem_ack     in   1   imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  current instruction to decode/controller
//  instr_valid  out  1   instr and pc are valid
//  instr_ready  in   1   datapath retires instr this cycle (redirect inputs sampled now)
//  pc           out  32  address of instr
//  pcplus4      out  32  pc + 4 (link value)
//  pcsrc        in   1   conditional branch taken (from controller)
//  jump         in   1   J-type jump
//  jumpr        in   1   register jump
//  signimm      in   32  sign-extended 16-bit branch offset
//  rs_data      in   32  register value for jumpr
//  fetch_err    out  1   sticky: ack timeout
//  misalign_err out  1   sticky: jumpr target low 2 bits nonzero
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, both err flags=0, timer=0.
//  FSM IDLE -> REQ unconditionally next cycle.
//   REQ : imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1, -> HOLD.
//         timer counts cycles in REQ; at ACK_TIMEOUT without ack: fetch_err<=1, -> STALL.
//   HOLD: instr_valid=1, imem_req=0. On instr_ready: pc<=next_pc, instr_valid<=0, -> REQ.
//   STALL: all outputs frozen, imem_req=0, instr_valid=0; left only by reset.
//  Latency: ack in cycle N -> instr_valid in N+1; retire in cycle M -> imem_req for next_pc in M+1.
//  Throughput: at most one instruction per 2 cycles with zero-wait imem.
//  next_pc priority: jumpr > jump > pcsrc > sequential.
//   jumpr : {rs_data[31:2],2'b00}; if rs_data[1:0]!=0 set misalign_err (execution continues).
//   jump  : {pcplus4[31:28], instr[25:0], 2'b00}
//   pcsrc : pcplus4 + {signimm[29:0],2'b00}
//   else  : pcplus4
//  All adds modulo 2^32 (pc 32'hFFFF_FFFC + 4 wraps to 0, no error).
//  Redirect inputs ignored unless instr_valid & instr_ready in HOLD.
//  instr_ready while not in HOLD is ignored. imem_ack outside REQ is ignored.
//  imem_addr holds its value while imem_req=0 (no glitching to 0).
//  Timer clears on entry to REQ; ack arriving on the ACK_TIMEOUT cycle counts as success.
//  Reset asserted mid-REQ/HOLD: abandons request and instruction; next cycle = reset state.
// STRUCTURE
//  Shared package mips_defs: FSM state encodings (IDLE/REQ/HOLD/STALL), RESET_PC default,
//   J-target field positions (instr[25:0]), word-align constant.
//  One sub-module: next_pc_sel (combinational: pcplus4, instr, signimm, rs_data, pcsrc,
//   jump, jumpr -> next_pc, misalign). Timer and FSM stay in this module.
// TESTING
//  1 Reset, ack same cycle as req, rdata=32'h2008_0005, ready next -> instr_valid 1 cycle after ack, pc=0, next req addr=4.
//  2 Retire with pcsrc=1, signimm=32'hFFFF_FFFE at pc=0x10 -> next imem_addr=0x0C.
//  3 Retire with jump=1, instr=32'h0800_0040, pc=0x1000_0000 -> imem_addr=0x1000_0100; jumpr=1 simultaneously with rs_data=0x20 -> 0x20 wins.
//  4 jumpr=1, rs_data=32'h0000_0042 -> imem_addr=0x40, misalign_err=1 and stays 1.
//  5 Withhold ack ACK_TIMEOUT cycles -> fetch_err=1, imem_req=0, instr_valid stays 0 until reset.
//  6 pc=0xFFFF_FFFC sequential retire -> imem_addr=0; reset asserted in HOLD -> next cycle pc=RESET_PC, instr_valid=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encoding, reset PC, J-target field and word alignment.
package mips_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_STALL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          JTGT_MSB         = 25;
  localparam int          JTGT_LSB         = 0;
  localparam logic [1:0]  WORD_ALIGN       = 2'b00;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], WORD_ALIGN};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: imem req/ack side plus the decode/controller side of the front end.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        pcsrc;
  logic        jump;
  logic        jumpr;
  logic [31:0] signimm;
  logic [31:0] rs_data;
  logic        fetch_err;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pcplus4, fetch_err, misalign_err,
    input  imem_ack, imem_rdata, instr_ready, pcsrc, jump, jumpr, signimm, rs_data
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pcplus4, fetch_err, misalign_err,
    output imem_ack, imem_rdata, instr_ready, pcsrc, jump, jumpr, signimm, rs_data
  );
endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC selection on retire: jumpr > jump > pcsrc > sequential, all adds modulo 2^32.
module next_pc_sel
  import mips_defs::*;
(
  input  logic [31:0] pcplus4_i,
  input  logic [25:0] jtgt_i,
  input  logic [31:0] signimm_i,
  input  logic [31:0] rs_data_i,
  input  logic        pcsrc_i,
  input  logic        jump_i,
  input  logic        jumpr_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  always_comb begin
    next_pc_o  = pcplus4_i;
    misalign_o = 1'b0;
    if (jumpr_i) begin
      next_pc_o  = word_align(rs_data_i);
      misalign_o = |rs_data_i[1:0];
    end else if (jump_i) begin
      next_pc_o = {pcplus4_i[31:28], jtgt_i, WORD_ALIGN};
    end else if (pcsrc_i) begin
      // shifting out signimm[31:30] is the word-offset scaling
      next_pc_o = pcplus4_i + (signimm_i << 2);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch front end: PC ownership, imem req/ack fetch with timeout, retire redirect.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | imem_req high at pc, waiting for imem_ack
// HOLD  | instr valid, waiting for the datapath to retire it
// STALL | imem never answered; frozen until reset
module instr_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic          instr_valid_q;
  logic          imem_req_q;
  logic [31:0]   imem_addr_q;
  logic          fetch_err_q;
  logic          misalign_q;
  logic [TW-1:0] timer_q;

  logic [31:0]   pcplus4;
  logic [31:0]   next_pc;
  logic          misalign;

  assign pcplus4 = pc_q + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pcplus4_i  (pcplus4),
    .jtgt_i     (instr_q[JTGT_MSB:JTGT_LSB]),
    .signimm_i  (bus.signimm),
    .rs_data_i  (bus.rs_data),
    .pcsrc_i    (bus.pcsrc),
    .jump_i     (bus.jump),
    .jumpr_i    (bus.jumpr),
    .next_pc_o  (next_pc),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      fetch_err_q   <= 1'b0;
      misalign_q    <= 1'b0;
      timer_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_REQ;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
          timer_q     <= '0;
        end
        ST_REQ: begin
          // ack on the last allowed cycle still wins over the timeout
          if (bus.imem_ack) begin
            instr_q       <= bus.imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= ST_HOLD;
          end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
            fetch_err_q <= 1'b1;
            imem_req_q  <= 1'b0;
            state_q     <= ST_STALL;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready && instr_valid_q) begin
            pc_q          <= next_pc;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            imem_addr_q   <= next_pc;
            timer_q       <= '0;
            state_q       <= ST_REQ;
            if (misalign) misalign_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_STALL;
        end
      endcase
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.pc           = pc_q;
  assign bus.pcplus4      = pcplus4;
  assign bus.fetch_err    = fetch_err_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with address/instruction scoreboard queues.
module tb_instr_fetch_unit;

  localparam int ACK_TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.pcsrc       = 1'b0;
    bus.jump        = 1'b0;
    bus.jumpr       = 1'b0;
    bus.signimm     = 32'h0;
    bus.rs_data     = 32'h0;
  endtask

  // Wait for the request, check its address, then ack after wait_n extra REQ cycles.
  task automatic fetch(input logic [31:0] rdata, input int wait_n);
    int n;
    logic [31:0] exp_a;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      tick();
      n++;
    end
    exp_a = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
    chk1("req_seen", bus.imem_req, 1'b1);
    chk("imem_addr", bus.imem_addr, exp_a);
    // ready and a redirect during REQ must be ignored
    bus.instr_ready = 1'b1;
    bus.jumpr       = 1'b1;
    bus.rs_data     = 32'h0000_0999;
    repeat (wait_n) tick();
    if (wait_n > 0) chk1("req_held", bus.imem_req, 1'b1);
    clear_inputs();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    instr_q.push_back(rdata);
    tick();
    bus.imem_ack = 1'b0;
    chk1("instr_valid", bus.instr_valid, 1'b1);
    chk("instr", bus.instr, (instr_q.size() > 0) ? instr_q.pop_front() : 32'hDEAD_BEEF);
    chk1("req_drop", bus.imem_req, 1'b0);
    chk("pc", bus.pc, exp_a);
    // a stray ack in HOLD must not overwrite the instruction
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = ~rdata;
    tick();
    bus.imem_ack = 1'b0;
    chk("instr_hold", bus.instr, rdata);
  endtask

  task automatic retire(input logic ps, input logic j, input logic jr,
                        input logic [31:0] simm, input logic [31:0] rs,
                        input logic [31:0] exp_next);
    bus.pcsrc       = ps;
    bus.jump        = j;
    bus.jumpr       = jr;
    bus.signimm     = simm;
    bus.rs_data     = rs;
    bus.instr_ready = 1'b1;
    addr_q.push_back(exp_next);
    tick();
    clear_inputs();
    chk1("valid_clr", bus.instr_valid, 1'b0);
    chk1("req_next", bus.imem_req, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk1("rst_req", bus.imem_req, 1'b0);
    chk1("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk1("rst_ferr", bus.fetch_err, 1'b0);
    chk1("rst_merr", bus.misalign_err, 1'b0);
    reset = 1'b0;
    addr_q.push_back(32'h0);

    // 1: first fetch, sequential retire
    fetch(32'h2008_0005, 0);
    chk("pcplus4_0", bus.pcplus4, 32'h4);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
    fetch(32'h0000_0020, 0);

    // 2: branch backwards from 0x10
    retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h10, 32'h10);
    fetch(32'h1000_FFFE, 0);
    retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h0C);
    fetch(32'h0000_0000, 0);
    chk1("no_misalign", bus.misalign_err, 1'b0);

    // 3: jump (beats pcsrc), then jumpr beats jump
    retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h1000_0000, 32'h1000_0000);
    fetch(32'h0800_0040, 0);
    retire(1'b1, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 32'h1000_0100);
    fetch(32'h0800_0040, 0);
    retire(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'h20);
    fetch(32'h0000_0000, 2);

    // 4: misaligned jumpr, sticky flag
    retire(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0042, 32'h40);
    chk1("misalign_set", bus.misalign_err, 1'b1);
    fetch(32'h0000_0000, 0);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h44);
    fetch(32'h0000_0000, 1);
    chk1("misalign_sticky", bus.misalign_err, 1'b1);

    // 6: PC wrap, then reset in HOLD
    retire(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0);
    chk("pcplus4_wrap", bus.pcplus4, 32'h0);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    fetch(32'h0000_0000, 0);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
    fetch(32'hABCD_1234, 0);
    reset = 1'b1;
    tick();
    chk("hold_rst_pc", bus.pc, 32'h0);
    chk1("hold_rst_valid", bus.instr_valid, 1'b0);
    chk1("hold_rst_req", bus.imem_req, 1'b0);
    chk1("hold_rst_merr", bus.misalign_err, 1'b0);
    reset = 1'b0;

    // ack on the last allowed REQ cycle still succeeds
    addr_q.push_back(32'h0);
    fetch(32'h1234_5678, ACK_TO - 1);
    chk1("late_ack_noerr", bus.fetch_err, 1'b0);

    // 5: ack never arrives
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
    chk("to_addr", bus.imem_addr, (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_BEEF);
    cnt = 0;
    while (bus.imem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("req_cycles", cnt, ACK_TO);
    chk1("ferr_set", bus.fetch_err, 1'b1);
    chk1("stall_req", bus.imem_req, 1'b0);
    chk1("stall_valid", bus.instr_valid, 1'b0);
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 32'h5555_AAAA;
    bus.instr_ready = 1'b1;
    repeat (3) tick();
    clear_inputs();
    chk1("stall_valid2", bus.instr_valid, 1'b0);
    chk1("stall_req2", bus.imem_req, 1'b0);
    chk1("ferr_sticky", bus.fetch_err, 1'b1);
    chk("stall_addr", bus.imem_addr, 32'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("ferr_clr", bus.fetch_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
